// File: rtl/mem_clear_pkg.sv
// Shared types and helpers for the RAM-bank clear sequencer.
//   state_t       : sequencer states (idle, fill, verify, drain, done)
//   FILL_CONST    : fill mode writing the constant fill value
//   FILL_ADDR_XOR : fill mode writing address XOR fill value
//   pattern()     : fill word for an address; callers truncate to their data width
package mem_clear_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StVerify,
        StDrain,
        StDone
    } state_t;

    localparam int unsigned FILL_CONST    = 0;
    localparam int unsigned FILL_ADDR_XOR = 1;

    // Wide enough for any realistic address/data width; zero-extension of a
    // narrow address falls out of the caller's cast into this width.
    localparam int unsigned PAT_W = 64;

    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                 input logic [PAT_W-1:0] fill_value,
                                                 input int unsigned      mode);
        if (mode == FILL_ADDR_XOR) begin
            return addr ^ fill_value;
        end
        return fill_value;
    endfunction

endpackage

// File: rtl/mem_clear_seq_if.sv
// Control and RAM-port bundle of the clear sequencer.
//   loading, bank_mask                  : sweep start level and bank selection
//   cpu_addr, cpu_data, cpu_wren        : bus-side RAM port
//   ram_addr, ram_data, ram_wren, ram_q : bank-side RAM port (ram_q is 1-cycle read data)
//   busy, done                          : sweep status and completion pulse
//   verify_err, err_bank, err_addr      : sticky first read-back mismatch
// master: the loader/bus/RAM side; slave: the sequencer.
interface mem_clear_seq_if #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                            loading;
    logic [NUM_BANKS-1:0]            bank_mask;
    logic [ADDR_WIDTH-1:0]           cpu_addr;
    logic [DATA_WIDTH-1:0]           cpu_data;
    logic [NUM_BANKS-1:0]            cpu_wren;
    logic [ADDR_WIDTH-1:0]           ram_addr;
    logic [DATA_WIDTH-1:0]           ram_data;
    logic [NUM_BANKS-1:0]            ram_wren;
    logic [NUM_BANKS*DATA_WIDTH-1:0] ram_q;
    logic                            busy;
    logic                            done;
    logic                            verify_err;
    logic [BANK_W-1:0]               err_bank;
    logic [ADDR_WIDTH-1:0]           err_addr;

    modport master (
        output loading, bank_mask, cpu_addr, cpu_data, cpu_wren, ram_q,
        input  ram_addr, ram_data, ram_wren, busy, done, verify_err, err_bank, err_addr
    );

    modport slave (
        input  loading, bank_mask, cpu_addr, cpu_data, cpu_wren, ram_q,
        output ram_addr, ram_data, ram_wren, busy, done, verify_err, err_bank, err_addr
    );

endinterface

// File: rtl/mem_clear_verify.sv
// Read-back checker for the clear sequencer.
//   clk_sys, reset : clock and synchronous active-high reset
//   clear          : start of a new sweep; drops any captured error
//   compare_en     : a read of addr is being issued this cycle
//   addr, expected : read address and the word it should hold
//   mask           : banks taking part in the sweep
//   ram_q          : bank read data, one cycle after the read
//   verify_err, err_bank, err_addr : sticky first mismatch
module mem_clear_verify #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BANK_W     = 1
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            compare_en,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           expected,
    input  logic [NUM_BANKS-1:0]            mask,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_q,
    output logic                            verify_err,
    output logic [BANK_W-1:0]               err_bank,
    output logic [ADDR_WIDTH-1:0]           err_addr
);
    // Address/expected word travel alongside the registered RAM read.
    logic                  vld_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic                  err_q;
    logic [BANK_W-1:0]     bank_q;
    logic [ADDR_WIDTH-1:0] eaddr_q;
    logic [NUM_BANKS-1:0]  miss;
    logic [BANK_W-1:0]     first_bank;

    always_comb begin
        miss       = '0;
        first_bank = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            miss[b] = mask[b] && (ram_q[b*DATA_WIDTH +: DATA_WIDTH] != exp_q);
        end
        // Scan downwards so the lowest mismatching bank wins.
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (miss[b]) begin
                first_bank = BANK_W'(b);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vld_q   <= 1'b0;
            addr_q  <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            bank_q  <= '0;
            eaddr_q <= '0;
        end else begin
            vld_q  <= compare_en;
            addr_q <= addr;
            exp_q  <= expected;
            if (clear) begin
                err_q   <= 1'b0;
                bank_q  <= '0;
                eaddr_q <= '0;
            end else if (vld_q && (|miss) && !err_q) begin
                err_q   <= 1'b1;
                bank_q  <= first_bank;
                eaddr_q <= addr_q;
            end
        end
    end

    assign verify_err = err_q;
    assign err_bank   = bank_q;
    assign err_addr   = eaddr_q;

endmodule

// File: rtl/mem_clear_seq.sv
// Power-up/load-time initialiser for the system RAM banks. A rising edge of
// loading sweeps every address of the selected banks with a fill pattern,
// optionally reads it all back, then pulses done. Idle: transparent bus port.
//   clk_sys, reset : clock and synchronous active-high reset
//   bus            : loader, bus-side and bank-side signals (see mem_clear_seq_if)
module mem_clear_seq
    import mem_clear_pkg::*;
#(
    parameter int unsigned           NUM_BANKS  = 2,
    parameter int unsigned           ADDR_WIDTH = 11,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
    parameter int unsigned           FILL_MODE  = FILL_CONST,
    parameter bit                    VERIFY     = 1'b1
) (
    input logic           clk_sys,
    input logic           reset,
    mem_clear_seq_if.slave bus
);
    localparam int unsigned           BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_BANKS-1:0]  mask_q, mask_d;
    logic                  loading_q;
    logic                  start;
    logic                  clear;
    logic                  compare_en;
    logic [DATA_WIDTH-1:0] fill_word;

    assign start     = bus.loading & ~loading_q;
    assign fill_word = DATA_WIDTH'(pattern(PAT_W'(cnt_q), PAT_W'(FILL_VALUE), FILL_MODE));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mask_q    <= '0;
            loading_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            loading_q <= bus.loading;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        clear        = 1'b0;
        compare_en   = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.ram_addr = bus.cpu_addr;
        bus.ram_data = bus.cpu_data;
        bus.ram_wren = bus.cpu_wren;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d  = bus.bank_mask;
                    cnt_d   = '0;
                    clear   = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                bus.busy     = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_data = fill_word;
                bus.ram_wren = mask_q;
                cnt_d        = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = VERIFY ? StVerify : StDone;
                end
            end
            StVerify: begin
                bus.busy     = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_data = fill_word;
                bus.ram_wren = '0;
                compare_en   = 1'b1;
                cnt_d        = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Last read's data arrives now; the checker compares it.
                bus.busy     = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_data = fill_word;
                bus.ram_wren = '0;
                state_d      = StDone;
            end
            StDone: begin
                bus.done     = 1'b1;
                bus.ram_addr = cnt_q;
                bus.ram_data = fill_word;
                bus.ram_wren = '0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    mem_clear_verify #(
        .NUM_BANKS (NUM_BANKS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BANK_W    (BANK_W)
    ) u_verify (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .clear     (clear),
        .compare_en(compare_en),
        .addr      (cnt_q),
        .expected  (fill_word),
        .mask      (mask_q),
        .ram_q     (bus.ram_q),
        .verify_err(bus.verify_err),
        .err_bank  (bus.err_bank),
        .err_addr  (bus.err_addr)
    );

endmodule

// File: tb/tb_mem_clear_seq.sv
// Bench for mem_clear_seq: three configurations (constant fill with verify,
// address-XOR fill with verify, constant fill without verify), each with its
// own two-bank registered RAM model.
module tb_mem_clear_seq;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic       loading_s [3];
    logic [1:0] mask_s    [3];
    logic [3:0] caddr_s   [3];
    logic [7:0] cdata_s   [3];
    logic [1:0] cwren_s   [3];
    logic       preload_s [3];
    logic       fault_on;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       verr;
        logic       ebank;
        logic [3:0] eaddr;
        logic [3:0] raddr;
        logic [7:0] rdata;
        logic [1:0] rwren;
    } obs_t;
    obs_t obs [3];

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int unsigned FM = (g == 1) ? 1 : 0;
        localparam logic [7:0]  FV = (g == 1) ? 8'hA5 : 8'h00;
        localparam bit          VF = (g != 2);

        mem_clear_seq_if #(.NUM_BANKS(2), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

        mem_clear_seq #(
            .NUM_BANKS (2),
            .ADDR_WIDTH(4),
            .DATA_WIDTH(8),
            .FILL_VALUE(FV),
            .FILL_MODE (FM),
            .VERIFY    (VF)
        ) dut (
            .clk_sys(clk_sys),
            .reset  (reset),
            .bus    (bus)
        );

        logic [7:0]  mem [2][16];
        logic [15:0] q_r;
        int unsigned wr_cycles;

        assign bus.loading   = loading_s[g];
        assign bus.bank_mask = mask_s[g];
        assign bus.cpu_addr  = caddr_s[g];
        assign bus.cpu_data  = cdata_s[g];
        assign bus.cpu_wren  = cwren_s[g];
        assign bus.ram_q     = q_r;
        assign obs[g] = {bus.busy, bus.done, bus.verify_err, bus.err_bank, bus.err_addr,
                         bus.ram_addr, bus.ram_data, bus.ram_wren};

        // Registered RAM; fault_on corrupts reads of address 7 (both banks)
        // and address 9 (bank 1 only).
        always_ff @(posedge clk_sys) begin
            for (int b = 0; b < 2; b++) begin
                if (preload_s[g]) begin
                    for (int a = 0; a < 16; a++) mem[b][a] <= 8'hFF;
                end else if (bus.ram_wren[b]) begin
                    mem[b][bus.ram_addr] <= bus.ram_data;
                end
                if (fault_on && ((bus.ram_addr == 4'd7) || (bus.ram_addr == 4'd9 && b == 1)))
                    q_r[b*8 +: 8] <= 8'h5A;
                else
                    q_r[b*8 +: 8] <= mem[b][bus.ram_addr];
            end
            if (reset) wr_cycles <= 0;
            else if (|bus.ram_wren) wr_cycles <= wr_cycles + 1;
        end
    end

    function automatic logic [7:0] rd_mem(input int inst, input int b, input int a);
        case (inst)
            0:       return gi[0].mem[b][a];
            1:       return gi[1].mem[b][a];
            default: return gi[2].mem[b][a];
        endcase
    endfunction

    function automatic int unsigned get_wr(input int inst);
        case (inst)
            0:       return gi[0].wr_cycles;
            1:       return gi[1].wr_cycles;
            default: return gi[2].wr_cycles;
        endcase
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Counts cycles from the current cycle 0; dcyc = -1 if done never pulses.
    task automatic wait_done(input int inst, input int budget, output int dcyc, output int bcyc);
        dcyc = -1;
        bcyc = 0;
        for (int c = 1; c <= budget; c++) begin
            step();
            #2;
            if (obs[inst].busy) bcyc++;
            if (obs[inst].done) begin
                dcyc = c;
                break;
            end
        end
    endtask

    typedef struct {
        int         inst;
        logic [1:0] mask;
        logic       preload;
        logic       fault;
        int         exp_done;
        int         exp_wr;
        logic       exp_err;
        logic       exp_ebank;
        logic [3:0] exp_eaddr;
        int         mb;
        int         ma;
        logic [7:0] mval;
    } vec_t;

    vec_t        vt [6];
    int          inst, dc, bc;
    int unsigned w0;

    initial begin
        vt[0] = '{0, 2'b11, 1'b1, 1'b0, 34, 16, 1'b0, 1'b0, 4'h0, 1, 5,  8'h00};
        vt[1] = '{1, 2'b01, 1'b1, 1'b0, 34, 16, 1'b0, 1'b0, 4'h0, 0, 3,  8'hA6};
        vt[2] = '{0, 2'b11, 1'b0, 1'b1, 34, 16, 1'b1, 1'b0, 4'h7, 1, 9,  8'h00};
        vt[3] = '{2, 2'b11, 1'b1, 1'b0, 17, 16, 1'b0, 1'b0, 4'h0, 0, 15, 8'h00};
        vt[4] = '{0, 2'b00, 1'b1, 1'b0, 34, 0,  1'b0, 1'b0, 4'h0, 0, 2,  8'hFF};
        vt[5] = '{0, 2'b10, 1'b1, 1'b1, 34, 16, 1'b1, 1'b1, 4'h7, 0, 0,  8'hFF};

        fault_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            loading_s[k] = 1'b0;
            mask_s[k]    = 2'b00;
            caddr_s[k]   = 4'h0;
            cdata_s[k]   = 8'h00;
            cwren_s[k]   = 2'b00;
            preload_s[k] = 1'b1;
        end
        reset = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) preload_s[k] = 1'b0;
        reset = 1'b0;
        #2;
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state_%0d", k),
                32'({obs[k].busy, obs[k].done, obs[k].verr, obs[k].ebank, obs[k].eaddr}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            inst = vt[i].inst;
            if (vt[i].preload) begin
                preload_s[inst] = 1'b1;
                step();
                preload_s[inst] = 1'b0;
            end
            fault_on     = vt[i].fault;
            mask_s[inst] = vt[i].mask;
            w0           = get_wr(inst);
            loading_s[inst] = 1'b1;
            wait_done(inst, 60, dc, bc);
            chk($sformatf("v%0d_done_cycle", i), dc, vt[i].exp_done);
            chk($sformatf("v%0d_busy_cycles", i), bc, vt[i].exp_done - 1);
            chk($sformatf("v%0d_verify_err", i), 32'(obs[inst].verr), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_err_bank", i), 32'(obs[inst].ebank), 32'(vt[i].exp_ebank));
            chk($sformatf("v%0d_err_addr", i), 32'(obs[inst].eaddr), 32'(vt[i].exp_eaddr));
            step();
            #2;
            chk($sformatf("v%0d_done_pulse", i), 32'({obs[inst].done, obs[inst].busy}), 32'd0);
            repeat (3) step();
            #2;
            chk($sformatf("v%0d_no_resweep", i), 32'(obs[inst].busy), 32'd0);
            chk($sformatf("v%0d_write_cycles", i), 32'(get_wr(inst) - w0), 32'(vt[i].exp_wr));
            chk($sformatf("v%0d_mem", i), 32'(rd_mem(inst, vt[i].mb, vt[i].ma)), 32'(vt[i].mval));
            chk($sformatf("v%0d_err_hold", i),
                32'({obs[inst].verr, obs[inst].ebank, obs[inst].eaddr}),
                32'({vt[i].exp_err, vt[i].exp_ebank, vt[i].exp_eaddr}));
            loading_s[inst] = 1'b0;
            fault_on        = 1'b0;
            step();
        end
        chk("xor_bank1_untouched", 32'(rd_mem(1, 1, 3)), 32'hFF);
        chk("xor_bank0_addr0", 32'(rd_mem(1, 0, 0)), 32'hA5);

        // Pass-through in idle, then masked bus writes and a loading toggle mid-fill.
        caddr_s[0] = 4'd3;
        cdata_s[0] = 8'h3C;
        cwren_s[0] = 2'b10;
        #2;
        chk("pass_addr", 32'(obs[0].raddr), 32'd3);
        chk("pass_data", 32'(obs[0].rdata), 32'h3C);
        chk("pass_wren", 32'(obs[0].rwren), 32'd2);
        step();
        cwren_s[0] = 2'b00;
        #1;
        chk("pass_write", 32'(rd_mem(0, 1, 3)), 32'h3C);
        mask_s[0]    = 2'b11;
        loading_s[0] = 1'b1;
        dc = -1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 2)  cwren_s[0] = 2'b10;
            if (c == 4)  loading_s[0] = 1'b0;
            if (c == 6)  loading_s[0] = 1'b1;
            if (c == 12) cwren_s[0] = 2'b00;
            #2;
            if (c == 5) begin
                chk("fill_addr", 32'(obs[0].raddr), 32'd4);
                chk("fill_data", 32'(obs[0].rdata), 32'h00);
                chk("fill_wren", 32'(obs[0].rwren), 32'd3);
            end
            if (obs[0].done) begin
                dc = c;
                break;
            end
        end
        chk("toggle_done_cycle", dc, 34);
        repeat (3) step();
        #2;
        chk("toggle_no_resweep", 32'(obs[0].busy), 32'd0);
        chk("fill_masked_bank1", 32'(rd_mem(0, 1, 3)), 32'h00);
        loading_s[0] = 1'b0;
        caddr_s[0]   = 4'h0;
        cdata_s[0]   = 8'h00;
        step();

        // Reset at cycle 8 with loading held high; restart right after.
        mask_s[0]    = 2'b11;
        loading_s[0] = 1'b1;
        for (int c = 1; c <= 8; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        chk("reset_mid_outputs", 32'(obs[0]), 32'd0);
        step();
        #2;
        chk("restart_busy", 32'(obs[0].busy), 32'd1);
        chk("restart_addr", 32'(obs[0].raddr), 32'd0);
        chk("restart_wren", 32'(obs[0].rwren), 32'd3);
        wait_done(0, 60, dc, bc);
        chk("restart_done", dc, 33);
        chk("restart_err", 32'(obs[0].verr), 32'd0);
        loading_s[0] = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_clear_seq.md
# mem_clear_seq

Parametrised power-up/load-time memory initialiser for the console system RAM banks, sitting between the CPU/DMA bus and the bank `spram` instances. It replaces the free-running `clear_addr` counter with the following:
- a start-on-edge sweep with an explicit state machine;
- per-bank selection and a selectable fill pattern;
- an optional read-back verify pass with error capture;
- a busy/done handshake that the loader and the CPU-reset logic can wait on.

While idle it is a transparent pass-through of the bus-side RAM port.

## Interface
Parameters:
- NUM_BANKS, 2: number of RAM banks sharing address and data lines.
- ADDR_WIDTH, 11: bank address width. Each sweep covers N = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: word width.
- FILL_VALUE, 0: constant used by the fill pattern.
- FILL_MODE, 0:
  - 0 writes FILL_VALUE.
  - 1 writes addr[DATA_WIDTH-1:0] ^ FILL_VALUE. The address is zero-extended if ADDR_WIDTH < DATA_WIDTH.
- VERIFY, 1: 1 enables the read-back pass; 0 omits it.

Ports:
- clk_sys, in, 1: system clock. One clock; reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- loading, in, 1: level. A rising edge starts a sweep.
- bank_mask, in, NUM_BANKS: banks to clear. Sampled at start.
- cpu_addr, in, ADDR_WIDTH: bus-side address.
- cpu_data, in, DATA_WIDTH: bus-side write data.
- cpu_wren, in, NUM_BANKS: bus-side per-bank write enables (already qualified by chip select and pclk0).
- ram_addr, out, ADDR_WIDTH: to the banks.
- ram_data, out, DATA_WIDTH: to the banks.
- ram_wren, out, NUM_BANKS: to the banks.
- ram_q, in, NUM_BANKS*DATA_WIDTH: bank read data. Bank b occupies bits [b*DW +: DW]. Registered RAM with 1-cycle latency.
- busy, out, 1: sweep in progress.
- done, out, 1: one-cycle pulse on completion.
- verify_err, out, 1: sticky mismatch flag.
- err_bank, out, $clog2(NUM_BANKS) (min 1): bank of the first mismatch.
- err_addr, out, ADDR_WIDTH: address of the first mismatch.

## Operation
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- Start condition: `loading & ~loading_q`, where loading_q is registered.
  - Acted on only in IDLE. Edges seen in any other state are ignored.
  - Falling loading mid-sweep does not abort.
- On start:
  - bank_mask is latched into mask_q.
  - The address counter is cleared.
  - verify_err, err_bank and err_addr are cleared.
  - The FSM moves to FILL.
- FILL:
  - ram_addr = counter, ram_data = pattern(counter), ram_wren = mask_q.
  - The counter increments each cycle.
  - At counter = N-1 the counter wraps to 0 and the FSM goes to VERIFY if VERIFY=1, otherwise to DONE.
- VERIFY:
  - ram_addr = counter, ram_wren = 0. The counter increments.
  - The address and expected pattern are delayed one cycle alongside ram_q.
  - At counter = N-1 the FSM goes to DRAIN.
- DRAIN: one cycle to compare the last word. ram_wren = 0. Then the FSM goes to DONE.
- Compare:
  - For each bank b with mask_q[b]=1, check ram_q[b] against the delayed expected value.
  - On the first mismatch of a sweep (verify_err still 0): set verify_err, and capture err_addr and err_bank. When several banks mismatch at the same address, the lowest bank index is captured.
  - Later mismatches do not update the captured fields.
- DONE: done=1 for one cycle, then IDLE.
- IDLE: ram_addr = cpu_addr, ram_data = cpu_data, ram_wren = cpu_wren. This is a combinational pass-through.
- While busy, cpu_wren is masked to 0 and cpu_addr/cpu_data are ignored.
- bank_mask = 0: the full sweep timing still runs with no writes and no compares, and done still pulses.
- Reset, including mid-sweep:
  - state returns to IDLE and the counter is cleared.
  - busy=0, done=0, verify_err=0, err_bank=0, err_addr=0, loading_q=0.
  - Partially written RAM contents are left as they are.
  - A loading input held high through reset starts a sweep on the first cycle after reset, because loading_q is reset to 0.

## Timing
- Cycle 0 is the first cycle in which loading is sampled high with loading_q = 0.
- busy=1 in FILL, VERIFY and DRAIN. busy=0 in IDLE and DONE.
- With VERIFY=1:
  - FILL writes address i in cycle 1+i, for i = 0..N-1.
  - VERIFY presents address i in cycle N+1+i.
  - The compare for address i occurs in cycle N+2+i. The last compare is in DRAIN, cycle 2N+1.
  - done is high in cycle 2N+2. The error outputs are valid from cycle 2N+2 and stay valid until the next start.
- With VERIFY=0: done is high in cycle N+1.
- Pass-through has zero latency. The bus port is back in pass-through in the cycle after done.

## Structure
- Package mem_clear_pkg holds:
  - state_t enum (IDLE, FILL, VERIFY, DRAIN, DONE).
  - FILL_CONST / FILL_ADDR_XOR localparams.
  - a pure function pattern(addr, fill_value, mode).
- Sub-module mem_clear_verify: the one-cycle-delayed expected/address pipeline, the per-bank comparator, the lowest-index priority encoder, and the sticky first-error capture. It takes clk_sys, reset, clear, and compare_en.
- The top holds loading edge detection, the FSM, the counter, and the bus mux.

## Test plan
All scenarios use NUM_BANKS=2, ADDR_WIDTH=4, DATA_WIDTH=8.

1. Constant fill:
   - Stimulus: FILL_VALUE=8'h00, mask=2'b11, VERIFY=1, loading raised at cycle 0 with RAM preloaded with 8'hFF.
   - Response: 16 writes in cycles 1..16, both banks read 8'h00, done at cycle 34, verify_err=0.
2. Address-XOR pattern:
   - Stimulus: FILL_MODE=1, FILL_VALUE=8'hA5, mask=2'b01.
   - Response: bank0[3]=8'hA6, bank1 unchanged, done at 34.
3. Fault injection:
   - Stimulus: force both banks' ram_q to 8'h5A when the read address is 7, then also at address 9 on bank1.
   - Response: verify_err=1, err_bank=0, err_addr=4'h7; the later miss at address 9 leaves the capture unchanged.
4. Pass-through and masking:
   - Stimulus: in IDLE, cpu_wren=2'b10, cpu_addr=3, cpu_data=8'h3C. Then repeat the write during FILL.
   - Response: bank1[3]=8'h3C after the IDLE write. The FILL-time write is masked and the bank holds the fill value.
5. Edge rules:
   - Stimulus 1: hold loading high through done. Response: no second sweep.
   - Stimulus 2: toggle loading mid-FILL. Response: ignored.
   - Stimulus 3: VERIFY=0. Response: done at cycle 17.
   - Stimulus 4: mask=0. Response: no ram_wren; done at cycle 34.
6. Reset mid-sweep:
   - Stimulus: assert reset at cycle 8 with loading held high.
   - Response: all outputs are 0 on the next cycle, and a fresh sweep starts in the cycle after reset deasserts.
